// File: rtl/mem_cache_subsystem.sv
// rtl/mem_cache_subsystem.sv - direct-mapped write-back cache over a latency-modelled word memory
module mem_cache_subsystem #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int MEM_WORDS      = 1024,
   parameter int MEM_LATENCY    = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              LOAD,
   input  logic              STORE,
   input  logic [ADDR_W-1:0] input_address,
   input  logic [DATA_W-1:0] input_data,
   output logic [DATA_W-1:0] data,
   output logic              load_done,
   output logic              store_completed,
   output logic              busy,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
);
   localparam int MEM_AW = $clog2(MEM_WORDS);
   localparam int OFF_W  = $clog2(WORDS_PER_LINE);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = MEM_AW - OFF_W - IDX_W;
   localparam int LAT_W  = $clog2(MEM_LATENCY + 1);

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
   typedef logic [MEM_WORDS-1:0][DATA_W-1:0] mem_t;

   function automatic mem_t mem_init();
      mem_t m;
      for (int i = 0; i < MEM_WORDS; i++) m[i] = DATA_W'(i);
      return m;
   endfunction

   // Backing store powers up holding its own word address; it is never reset.
   mem_t mem = mem_init();

   logic [DATA_W-1:0] line_mem [NUM_LINES*WORDS_PER_LINE];
   logic [TAG_W-1:0]  tag_arr  [NUM_LINES];
   logic [NUM_LINES-1:0] valid, dirty;

   state_t            state, state_n;
   logic              req_load;
   logic [MEM_AW-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [LAT_W-1:0]  lat_cnt;
   logic [OFF_W-1:0]  word_cnt;

   logic [OFF_W-1:0]  req_off;
   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic              hit, beat_last, line_last;

   assign req_off   = req_addr[OFF_W-1:0];
   assign req_idx   = req_addr[OFF_W +: IDX_W];
   assign req_tag   = req_addr[MEM_AW-1 -: TAG_W];
   assign hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
   assign beat_last = (lat_cnt == LAT_W'(MEM_LATENCY - 1));
   assign line_last = (word_cnt == OFF_W'(WORDS_PER_LINE - 1));
   assign busy      = (state != IDLE);

   generate
      if (ADDR_W > MEM_AW) begin : g_addr_fold
         logic unused_addr_hi;
         assign unused_addr_hi = ^input_address[ADDR_W-1:MEM_AW];
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:      if (LOAD || STORE) state_n = LOOKUP;
         LOOKUP:    if (hit) state_n = RESPOND;
                    else if (dirty[req_idx]) state_n = WRITEBACK;
                    else state_n = REFILL;
         WRITEBACK: if (beat_last && line_last) state_n = REFILL;
         REFILL:    if (beat_last && line_last) state_n = RESPOND;
         RESPOND:   state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         data            <= '0;
         load_done       <= 1'b0;
         store_completed <= 1'b0;
         hit_count       <= '0;
         miss_count      <= '0;
         valid           <= '0;
         dirty           <= '0;
         lat_cnt         <= '0;
         word_cnt        <= '0;
         req_load        <= 1'b0;
         req_addr        <= '0;
         req_data        <= '0;
      end else begin
         load_done       <= 1'b0;
         store_completed <= 1'b0;
         case (state)
            IDLE: if (LOAD || STORE) begin
               req_load <= LOAD;
               req_addr <= input_address[MEM_AW-1:0];
               req_data <= input_data;
            end
            LOOKUP: begin
               lat_cnt  <= '0;
               word_cnt <= '0;
               if (hit) hit_count <= (hit_count == 16'hFFFF) ? hit_count : hit_count + 16'd1;
               else     miss_count <= (miss_count == 16'hFFFF) ? miss_count : miss_count + 16'd1;
            end
            WRITEBACK, REFILL: begin
               if (beat_last) begin
                  lat_cnt  <= '0;
                  word_cnt <= word_cnt + OFF_W'(1);
                  if (line_last && state == WRITEBACK) dirty[req_idx] <= 1'b0;
                  if (line_last && state == REFILL)    valid[req_idx] <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end
            RESPOND: begin
               if (req_load) begin
                  data      <= line_mem[{req_idx, req_off}];
                  load_done <= 1'b1;
               end else begin
                  dirty[req_idx]  <= 1'b1;
                  store_completed <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Storage arrays carry no reset; an aborting reset edge must not complete a beat.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (state == WRITEBACK && beat_last)
            mem[{tag_arr[req_idx], req_idx, word_cnt}] <= line_mem[{req_idx, word_cnt}];
         if (state == REFILL && beat_last)
            line_mem[{req_idx, word_cnt}] <= mem[{req_tag, req_idx, word_cnt}];
         if (state == REFILL && beat_last && line_last)
            tag_arr[req_idx] <= req_tag;
         if (state == RESPOND && !req_load)
            line_mem[{req_idx, req_off}] <= req_data;
      end
   end
endmodule

// File: tb/tb_mem_cache_subsystem.sv
// tb/tb_mem_cache_subsystem.sv - bench for mem_cache_subsystem
module tb_mem_cache_subsystem;
   logic        CLK = 1'b0;
   logic        RST, LOAD, STORE;
   logic [31:0] input_address, input_data, data;
   logic        load_done, store_completed, busy;
   logic [15:0] hit_count, miss_count;

   int checks = 0;
   int errors = 0;

   mem_cache_subsystem dut (
      .CLK(CLK), .RST(RST), .LOAD(LOAD), .STORE(STORE),
      .input_address(input_address), .input_data(input_data),
      .data(data), .load_done(load_done), .store_completed(store_completed),
      .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 CLK = ~CLK;

   // Reference: line = (addr/4)%16, tag = addr/64, over a 1024-word memory.
   logic [31:0] m_mem  [1024];
   logic [31:0] m_line [16][4];
   bit          m_valid[16];
   bit          m_dirty[16];
   int          m_tag  [16];
   logic [31:0] m_data;
   int          m_hits, m_misses;

   typedef struct {
      bit          ld;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_data;
      int          exp_lat;
      int          exp_hits;
      int          exp_misses;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
      end
      m_hits = 0;
      m_misses = 0;
      m_data = 0;
   endtask

   task automatic model_access(input bit ld, input logic [31:0] addr, input logic [31:0] wd,
                               output int lat);
      int a, off, idx, tag;
      a   = int'(addr % 32'd1024);
      off = a % 4;
      idx = (a / 4) % 16;
      tag = a / 64;
      if (m_valid[idx] && m_tag[idx] == tag) begin
         lat = 2;
         if (m_hits < 65535) m_hits++;
      end else begin
         lat = 18;
         if (m_misses < 65535) m_misses++;
         if (m_valid[idx] && m_dirty[idx]) begin
            lat = 34;
            for (int k = 0; k < 4; k++) m_mem[m_tag[idx]*64 + idx*4 + k] = m_line[idx][k];
         end
         for (int k = 0; k < 4; k++) m_line[idx][k] = m_mem[tag*64 + idx*4 + k];
         m_valid[idx] = 1;
         m_dirty[idx] = 0;
         m_tag[idx]   = tag;
      end
      if (ld) m_data = m_line[idx][off];
      else begin
         m_line[idx][off] = wd;
         m_dirty[idx] = 1;
      end
   endtask

   task automatic wait_pulse(output int n);
      n = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge CLK); #1;
         if (load_done || store_completed) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic run_op(input bit ld, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_data, input int exp_lat,
                         input int exp_hits, input int exp_misses, input string nm);
      int n;
      @(negedge CLK);
      LOAD = ld; STORE = !ld; input_address = addr; input_data = wd;
      @(posedge CLK); #1;
      check({nm, ".busy"}, 32'(busy), 32'd1);
      input_address = $urandom;
      input_data    = $urandom;
      wait_pulse(n);
      check({nm, ".latency"}, n, exp_lat);
      check({nm, ".load_done"}, 32'(load_done), 32'(ld));
      check({nm, ".store_completed"}, 32'(store_completed), 32'(!ld));
      check({nm, ".data"}, data, exp_data);
      check({nm, ".hits"}, 32'(hit_count), exp_hits);
      check({nm, ".misses"}, 32'(miss_count), exp_misses);
      check({nm, ".busy_after"}, 32'(busy), 32'd0);
      LOAD = 0; STORE = 0;
      @(posedge CLK); #1;
      check({nm, ".pulse_width"}, 32'(load_done | store_completed), 32'd0);
   endtask

   task automatic model_op(input bit ld, input logic [31:0] addr, input logic [31:0] wd,
                           input string nm);
      int lat;
      model_access(ld, addr, wd, lat);
      run_op(ld, addr, wd, m_data, lat, m_hits, m_misses, nm);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1; LOAD = 0; STORE = 0;
      @(posedge CLK); @(negedge CLK);
      RST = 0;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, lat, pulses;
      for (int i = 0; i < 1024; i++) m_mem[i] = i;
      tbl[0] = '{1'b1, 32'h20, 32'h0,        32'h20,       18, 0, 1};
      tbl[1] = '{1'b0, 32'h20, 32'hDEADBEEF, 32'h20,        2, 1, 1};
      tbl[2] = '{1'b1, 32'h20, 32'h0,        32'hDEADBEEF,  2, 2, 1};
      tbl[3] = '{1'b1, 32'h60, 32'h0,        32'h60,       34, 2, 2};
      tbl[4] = '{1'b1, 32'h20, 32'h0,        32'hDEADBEEF, 18, 2, 3};

      RST = 1; LOAD = 0; STORE = 0; input_address = 0; input_data = 0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset.data", data, 0);
      check("reset.load_done", 32'(load_done), 0);
      check("reset.store_completed", 32'(store_completed), 0);
      check("reset.busy", 32'(busy), 0);
      check("reset.hits", 32'(hit_count), 0);
      check("reset.misses", 32'(miss_count), 0);
      do_reset();

      for (int i = 0; i < 5; i++) begin
         model_access(tbl[i].ld, tbl[i].addr, tbl[i].wd, lat);
         run_op(tbl[i].ld, tbl[i].addr, tbl[i].wd, tbl[i].exp_data, tbl[i].exp_lat,
                tbl[i].exp_hits, tbl[i].exp_misses, $sformatf("vec%0d", i));
      end

      // LOAD and STORE together: load served first, held store follows.
      @(negedge CLK);
      LOAD = 1; STORE = 1; input_address = 32'h4; input_data = 32'h55;
      @(posedge CLK); #1;
      wait_pulse(n);
      check("both.load_latency", n, 18);
      check("both.load_done", 32'(load_done), 1);
      check("both.no_store_yet", 32'(store_completed), 0);
      check("both.load_data", data, 32'h4);
      LOAD = 0;
      wait_pulse(n);
      check("both.store_latency", n, 3);
      check("both.store_completed", 32'(store_completed), 1);
      check("both.data_kept", data, 32'h4);
      STORE = 0;
      model_access(1, 32'h4, 0, lat);
      model_access(0, 32'h4, 32'h55, lat);
      check("both.model_hits", 32'(hit_count), m_hits);
      check("both.model_misses", 32'(miss_count), m_misses);
      model_op(1, 32'h4, 0, "both.reload");
      check("both.reload_value", data, 32'h55);

      // Reset five cycles into a refill.
      @(negedge CLK);
      LOAD = 1; STORE = 0; input_address = 32'h120;
      @(posedge CLK); #1;
      pulses = 0;
      repeat (6) begin
         @(posedge CLK); #1;
         if (load_done || store_completed) pulses++;
      end
      check("abort.busy_before", 32'(busy), 1);
      @(negedge CLK);
      RST = 1; LOAD = 0;
      @(posedge CLK); #1;
      check("abort.no_pulse", pulses + int'(load_done) + int'(store_completed), 0);
      check("abort.busy", 32'(busy), 0);
      check("abort.hits", 32'(hit_count), 0);
      check("abort.misses", 32'(miss_count), 0);
      check("abort.data", data, 0);
      @(negedge CLK);
      RST = 0;
      model_reset();
      model_op(1, 32'h20, 0, "abort.reload");
      check("abort.reload_value", data, 32'hDEADBEEF);

      // Miss counter saturation.
      @(negedge CLK);
      force dut.miss_count = 16'hFFFE;
      @(posedge CLK);
      @(negedge CLK);
      release dut.miss_count;
      m_misses = 16'hFFFE;
      check("sat.preset", 32'(miss_count), 32'hFFFE);
      model_op(1, 32'h220, 0, "sat.first");
      check("sat.reach_max", 32'(miss_count), 32'hFFFF);
      model_op(1, 32'h320, 0, "sat.second");
      check("sat.hold_max", 32'(miss_count), 32'hFFFF);

      do_reset();
      for (int i = 0; i < 80; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 6) |
             ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         model_op(1'($urandom_range(0, 1)), a, $urandom, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
